// File: rtl/mem_lsu_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lsu_stage: MEM-stage load/store unit, dmem req/ack with timeout.     |
// | Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_lsu_stage #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_MemEn,
  input  logic        ex_MemRW,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_ALU_out,
  input  logic [31:0] ex_DataB,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        lsu_stall,
  output logic [31:0] mem_WBData,
  output logic        mem_done,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mem_done_q, mem_done_d;
  logic        bus_err_q, bus_err_d;
  logic [1:0]  byte_off_q, byte_off_d;
  logic [2:0]  funct3_q, funct3_d;

  logic        accept;
  logic        trap_new;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign accept = ex_valid & ex_MemEn;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign trap_new = (ex_funct3[1:0] == 2'b01) ? ex_ALU_out[0] :
                    (ex_funct3[1:0] == 2'b00) ? 1'b0 : (|ex_ALU_out[1:0]);
  assign misalign = misalign_q;
`else
  assign trap_new = 1'b0;
`endif

  // funct3[1:0] selects size (00 B, 01 H, else W); address bits below the size are dropped
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = ex_DataB;
    case (ex_funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << ex_ALU_out[1:0];
        wdata_new = {4{ex_DataB[7:0]}};
      end
      2'b01: begin
        be_new    = ex_ALU_out[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{ex_DataB[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (byte_off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = byte_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   ld_data = funct3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = funct3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_data_d    = wb_data_q;
    byte_off_d   = byte_off_q;
    funct3_d     = funct3_q;
    mem_done_d   = 1'b0;
    bus_err_d    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dmem_we_d    = ex_MemRW;
          dmem_addr_d  = {ex_ALU_out[31:2], 2'b00};
          dmem_be_d    = be_new;
          dmem_wdata_d = wdata_new;
          byte_off_d   = ex_ALU_out[1:0];
          funct3_d     = ex_funct3;
          wait_cnt_d   = 8'd0;
          if (trap_new) begin
            state_d    = S_DONE;
            mem_done_d = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
`endif
          end else begin
            state_d    = S_REQ;
            dmem_req_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        // an ack in the final wait cycle still wins over the timeout
        if (dmem_ack) begin
          state_d    = S_DONE;
          dmem_req_d = 1'b0;
          mem_done_d = 1'b1;
          if (!dmem_we_q) wb_data_d = ld_data;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_DONE;
          dmem_req_d = 1'b0;
          mem_done_d = 1'b1;
          bus_err_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 8'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_be_q    <= 4'd0;
      dmem_wdata_q <= 32'd0;
      wb_data_q    <= 32'd0;
      mem_done_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      byte_off_q   <= 2'd0;
      funct3_q     <= 3'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_data_q    <= wb_data_d;
      mem_done_q   <= mem_done_d;
      bus_err_q    <= bus_err_d;
      byte_off_q   <= byte_off_d;
      funct3_q     <= funct3_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // stall is combinational so the accept cycle already freezes the pipeline
  assign lsu_stall  = ~rst & ((state_q == S_REQ) | ((state_q == S_IDLE) & accept));
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign mem_WBData = wb_data_q;
  assign mem_done   = mem_done_q;
  assign bus_err    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_lsu_stage: vector table + scoreboard bench for mem_lsu_stage.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_lsu_stage;

  localparam int MAX_WAIT = 16;
  localparam int NO_ACK   = 1000;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_MemEn, ex_MemRW;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_ALU_out, ex_DataB;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        lsu_stall;
  logic [31:0] mem_WBData;
  logic        mem_done, bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  mem_lsu_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_MemEn(ex_MemEn), .ex_MemRW(ex_MemRW),
    .ex_funct3(ex_funct3), .ex_ALU_out(ex_ALU_out), .ex_DataB(ex_DataB),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .lsu_stall(lsu_stall), .mem_WBData(mem_WBData), .mem_done(mem_done),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] datab;
    logic [31:0] rdata;
    int          ack_wait;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    bit          mis;
  } vec_t;

  typedef struct {
    logic [31:0] wb;
    bit          err;
  } exp_t;

  vec_t        vecs[16];
  exp_t        sbq[$];
  logic [31:0] model_wb;
  int          cmp_cnt;
  int          err_cnt;

  function automatic vec_t mk(input logic [2:0] f3, input logic rw, input logic [31:0] addr,
                              input logic [31:0] datab, input logic [31:0] rdata, input int ack_wait,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_wb, input bit mis);
    vec_t v;
    v.f3 = f3; v.rw = rw; v.addr = addr; v.datab = datab; v.rdata = rdata;
    v.ack_wait = ack_wait; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_wb = exp_wb; v.mis = mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that leaves DONE.
  task automatic run_op(input vec_t v);
    int   cyc, reqc, stallc, first_req, done_cyc, exp_done, exp_req;
    bit   done_seen, trap, no_ack;
    exp_t e, got;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = v.mis;
`endif
    no_ack = (v.ack_wait == NO_ACK);
    ex_valid = 1'b1; ex_MemEn = 1'b1; ex_MemRW = v.rw;
    ex_funct3 = v.f3; ex_ALU_out = v.addr; ex_DataB = v.datab;
    e.wb  = (!v.rw && !no_ack && !trap) ? v.exp_wb : model_wb;
    e.err = no_ack && !trap;
    sbq.push_back(e);
    model_wb = e.wb;
    exp_done = trap ? 1 : (no_ack ? MAX_WAIT + 1 : v.ack_wait + 2);
    exp_req  = trap ? 0 : (no_ack ? MAX_WAIT : v.ack_wait + 1);
    cyc = 0; reqc = 0; stallc = 0; first_req = -1; done_cyc = -1; done_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      if (lsu_stall) stallc++;
      if (dmem_req) begin
        if (first_req < 0) first_req = cyc;
        check("bus_we_addr", {31'd0, dmem_we, dmem_addr}, {31'd0, v.rw, v.exp_addr});
        if (v.rw) check("bus_be_wdata", {28'd0, dmem_be, dmem_wdata}, {28'd0, v.exp_be, v.exp_wdata});
        if (reqc == v.ack_wait) begin
          dmem_ack   = 1'b1;
          dmem_rdata = v.rdata;
        end
        reqc++;
      end
      if (mem_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        check("done_stall_low", {63'd0, lsu_stall}, 64'd0);
        check("done_bus_err", {63'd0, bus_err}, {63'd0, e.err});
`ifdef LSU_MISALIGN_TRAP_EN
        check("done_misalign", {63'd0, misalign}, {63'd0, trap});
`endif
        if (sbq.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          got = sbq.pop_front();
          check("wb_data", {32'd0, mem_WBData}, {32'd0, got.wb});
        end
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      cyc++;
    end
    if (!done_seen) check("op_wait_budget", 64'd0, 64'd1);
    check("done_cycle", 64'(done_cyc), 64'(exp_done));
    check("stall_cycles", 64'(stallc), 64'(exp_done));
    check("req_cycles", 64'(reqc), 64'(exp_req));
    if (!trap) check("first_req_cycle", 64'(first_req), 64'd1);
    ex_valid = 1'b0;
    ex_MemEn = 1'b0;
    check("pulse_end", {62'd0, mem_done, bus_err}, 64'd0);
  endtask

  initial begin
    cmp_cnt = 0; err_cnt = 0; model_wb = 32'd0;
    rst = 1'b1;
    ex_valid = 1'b0; ex_MemEn = 1'b0; ex_MemRW = 1'b0;
    ex_funct3 = 3'd0; ex_ALU_out = 32'd0; ex_DataB = 32'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;

    //          f3     rw addr        datab         rdata         wait    exp_addr    be       wdata         wb            mis
    vecs[0]  = mk(3'b000, 0, 32'h103, 32'h0,        32'h80FF1234, 0,      32'h100, 4'h0,    32'h0,        32'hFFFFFF80, 0);
    vecs[1]  = mk(3'b101, 0, 32'h202, 32'h0,        32'hBEEF0000, 1,      32'h200, 4'h0,    32'h0,        32'h0000BEEF, 0);
    vecs[2]  = mk(3'b001, 0, 32'h200, 32'h0,        32'h00008001, 2,      32'h200, 4'h0,    32'h0,        32'hFFFF8001, 0);
    vecs[3]  = mk(3'b000, 1, 32'h301, 32'h000000A5, 32'h0,        0,      32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0,        0);
    vecs[4]  = mk(3'b010, 1, 32'h400, 32'h12345678, 32'h0,        5,      32'h400, 4'b1111, 32'h12345678, 32'h0,        0);
    vecs[5]  = mk(3'b010, 0, 32'h408, 32'h0,        32'hCAFEF00D, 0,      32'h408, 4'h0,    32'h0,        32'hCAFEF00D, 0);
    vecs[6]  = mk(3'b100, 0, 32'h501, 32'h0,        32'h0000F600, 3,      32'h500, 4'h0,    32'h0,        32'h000000F6, 0);
    vecs[7]  = mk(3'b001, 1, 32'h602, 32'hFFFFBEEF, 32'h0,        1,      32'h600, 4'b1100, 32'hBEEFBEEF, 32'h0,        0);
    vecs[8]  = mk(3'b001, 1, 32'h603, 32'h00001234, 32'h0,        0,      32'h600, 4'b1100, 32'h12341234, 32'h0,        1);
    vecs[9]  = mk(3'b010, 0, 32'h502, 32'h0,        32'h11223344, 0,      32'h500, 4'h0,    32'h0,        32'h11223344, 1);
    vecs[10] = mk(3'b011, 0, 32'h70C, 32'h0,        32'hA5A55A5A, 0,      32'h70C, 4'h0,    32'h0,        32'hA5A55A5A, 0);
    vecs[11] = mk(3'b000, 0, 32'h800, 32'h0,        32'h0000007F, 0,      32'h800, 4'h0,    32'h0,        32'h0000007F, 0);
    vecs[12] = mk(3'b000, 1, 32'h303, 32'hFFFFFF3C, 32'h0,        2,      32'h300, 4'b1000, 32'h3C3C3C3C, 32'h0,        0);
    vecs[13] = mk(3'b111, 1, 32'hB01, 32'hDEADBEEF, 32'h0,        0,      32'hB00, 4'b1111, 32'hDEADBEEF, 32'h0,        1);
    vecs[14] = mk(3'b001, 0, 32'h902, 32'h0,        32'h80007FFF, 0,      32'h900, 4'h0,    32'h0,        32'hFFFF8000, 0);
    vecs[15] = mk(3'b010, 0, 32'hA00, 32'h0,        32'h0,        NO_ACK, 32'hA00, 4'h0,    32'h0,        32'h0,        0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {59'd0, dmem_req, dmem_we, mem_done, bus_err, lsu_stall}, 64'd0);
    check("rst_addr", {32'd0, dmem_addr}, 64'd0);
    check("rst_be_wdata", {28'd0, dmem_be, dmem_wdata}, 64'd0);
    check("rst_wb", {32'd0, mem_WBData}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Consecutive calls drive the next op in the IDLE cycle right after DONE.
    for (int i = 0; i < 16; i++) run_op(vecs[i]);

    // Late ack after the timeout must be ignored.
    @(negedge clk);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_ctrl", {60'd0, dmem_req, mem_done, bus_err, lsu_stall}, 64'd0);
    check("late_ack_wb", {32'd0, mem_WBData}, {32'd0, model_wb});

    // Reset in the middle of a request.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_MemEn = 1'b1; ex_MemRW = 1'b1;
    ex_funct3 = 3'b010; ex_ALU_out = 32'hC04; ex_DataB = 32'h0BADF00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rm_req_before", {63'd0, dmem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rm_ctrl", {59'd0, dmem_req, dmem_we, mem_done, bus_err, lsu_stall}, 64'd0);
    check("rm_addr", {32'd0, dmem_addr}, 64'd0);
    check("rm_be_wdata", {28'd0, dmem_be, dmem_wdata}, 64'd0);
    check("rm_wb", {32'd0, mem_WBData}, 64'd0);
    ex_valid = 1'b0; ex_MemEn = 1'b0;
    model_wb = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rm_late_ctrl", {60'd0, dmem_req, mem_done, bus_err, lsu_stall}, 64'd0);
    check("rm_late_wb", {32'd0, mem_WBData}, {32'd0, model_wb});

    @(posedge clk); #1;
    run_op(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
